// File: rtl/lgn_class_argmax_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lgn_pkg
//  Description : Shared sizing constants and FSM encoding for the per-class
//                argmax classifier that follows the logic-gate network.
//  Revision    : 1.0 - initial release
// ============================================================================
package lgn_pkg;

    localparam int CLASSES   = 10;
    localparam int PER_CLASS = 400;
    localparam int SCORE_W   = $clog2(PER_CLASS) + 1;
    // A single class still needs a one-bit index register
    localparam int IDX_W     = (CLASSES > 1) ? $clog2(CLASSES) : 1;
    localparam int Y_W       = CLASSES * PER_CLASS;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SCAN = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/lgn_class_argmax_if.sv
`default_nettype none
// ============================================================================
//  Module      : lgn_class_argmax_if
//  Description : Request/result bundle between the network output stage and
//                the argmax classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lgn_class_argmax_if;
    import lgn_pkg::*;

    logic               start;
    logic [Y_W-1:0]     y;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   class_out;
    logic [SCORE_W-1:0] score_out;
    logic [SCORE_W-1:0] margin_out;

    modport master (
        output start,
        output y,
        input  busy,
        input  done,
        input  class_out,
        input  score_out,
        input  margin_out
    );

    modport slave (
        input  start,
        input  y,
        output busy,
        output done,
        output class_out,
        output score_out,
        output margin_out
    );

endinterface
`default_nettype wire

// File: rtl/lgn_class_argmax_group_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : group_popcount
//  Description : Purely combinational population count of an N-bit group.
//                Output is wide enough to hold N itself.
//  Revision    : 1.0 - initial release
// ============================================================================
module group_popcount #(
    parameter int N = 400
) (
    input  wire logic [N-1:0]       i_bits,
    output logic      [$clog2(N):0] o_count
);

    localparam int CW = $clog2(N) + 1;

    // Sum every bit of the group
    always_comb begin
        o_count = '0;
        for (int i = 0; i < N; i++) begin
            o_count = o_count + CW'(i_bits[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/lgn_class_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : lgn_class_argmax
//  Description : Scans the network output one class group per cycle,
//                popcounts it and keeps the running maximum. Reports the
//                winning class index and score with a one-cycle done pulse.
//                Optional macro LGN_ARGMAX_MARGIN_EN adds a second-best
//                tracker and drives margin_out = best - second best;
//                without it margin_out is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module lgn_class_argmax
    import lgn_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    lgn_class_argmax_if.slave  bus
);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [IDX_W-1:0]     best_idx_q, best_idx_d;
    logic [IDX_W-1:0]     class_out_q, class_out_d;
    logic [SCORE_W-1:0]   score_out_q, score_out_d;

    logic [PER_CLASS-1:0] slice_w;
    logic [SCORE_W-1:0]   score_w;
    logic                 take_w;
    logic                 last_w;
    logic [SCORE_W-1:0]   new_best_score_w;
    logic [IDX_W-1:0]     new_best_idx_w;

`ifdef LGN_ARGMAX_MARGIN_EN
    logic [SCORE_W-1:0]   second_score_q, second_score_d;
    logic [SCORE_W-1:0]   margin_out_q, margin_out_d;
    logic [SCORE_W-1:0]   new_second_w;
`endif

    // Select the class group addressed by the scan index
    always_comb begin
        slice_w = bus.y[0 +: PER_CLASS];
        for (int c = 0; c < CLASSES; c++) begin
            if (idx_q == IDX_W'(c)) begin
                slice_w = bus.y[c*PER_CLASS +: PER_CLASS];
            end
        end
    end

    group_popcount #(
        .N (PER_CLASS)
    ) u_popcount (
        .i_bits  (slice_w),
        .o_count (score_w)
    );

    // Running-max update; strict compare keeps the lower index on ties
    always_comb begin
        take_w           = (score_w > best_score_q) || (idx_q == '0);
        last_w           = (idx_q == IDX_W'(CLASSES - 1));
        new_best_score_w = take_w ? score_w : best_score_q;
        new_best_idx_w   = take_w ? idx_q   : best_idx_q;
`ifdef LGN_ARGMAX_MARGIN_EN
        // A displaced best becomes the second best; the first group has none
        if (take_w) begin
            new_second_w = (idx_q == '0) ? '0 : best_score_q;
        end else if (score_w > second_score_q) begin
            new_second_w = score_w;
        end else begin
            new_second_w = second_score_q;
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start outside IDLE is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_SCAN;
            ST_SCAN: if (last_w)    state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: busy covers SCAN and DONE, done is the DONE cycle
    always_comb begin
        bus.busy = (state_q == ST_SCAN) || (state_q == ST_DONE);
        bus.done = (state_q == ST_DONE);
    end

    // Datapath next values; results latch on the last SCAN cycle so they
    // are already valid while done is high
    always_comb begin
        idx_d          = idx_q;
        best_score_d   = best_score_q;
        best_idx_d     = best_idx_q;
        class_out_d    = class_out_q;
        score_out_d    = score_out_q;
`ifdef LGN_ARGMAX_MARGIN_EN
        second_score_d = second_score_q;
        margin_out_d   = margin_out_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    idx_d          = '0;
                    best_score_d   = '0;
                    best_idx_d     = '0;
`ifdef LGN_ARGMAX_MARGIN_EN
                    second_score_d = '0;
`endif
                end
            end
            ST_SCAN: begin
                best_score_d   = new_best_score_w;
                best_idx_d     = new_best_idx_w;
`ifdef LGN_ARGMAX_MARGIN_EN
                second_score_d = new_second_w;
`endif
                if (last_w) begin
                    class_out_d  = new_best_idx_w;
                    score_out_d  = new_best_score_w;
`ifdef LGN_ARGMAX_MARGIN_EN
                    margin_out_d = new_best_score_w - new_second_w;
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q          <= '0;
            best_score_q   <= '0;
            best_idx_q     <= '0;
            class_out_q    <= '0;
            score_out_q    <= '0;
`ifdef LGN_ARGMAX_MARGIN_EN
            second_score_q <= '0;
            margin_out_q   <= '0;
`endif
        end else begin
            idx_q          <= idx_d;
            best_score_q   <= best_score_d;
            best_idx_q     <= best_idx_d;
            class_out_q    <= class_out_d;
            score_out_q    <= score_out_d;
`ifdef LGN_ARGMAX_MARGIN_EN
            second_score_q <= second_score_d;
            margin_out_q   <= margin_out_d;
`endif
        end
    end

    assign bus.class_out = class_out_q;
    assign bus.score_out = score_out_q;
`ifdef LGN_ARGMAX_MARGIN_EN
    assign bus.margin_out = margin_out_q;
`else
    assign bus.margin_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lgn_class_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lgn_class_argmax
//  Description : Directed self-checking bench for lgn_class_argmax.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lgn_class_argmax;
    import lgn_pkg::*;

`ifdef LGN_ARGMAX_MARGIN_EN
    localparam bit MARGIN_ON = 1'b1;
`else
    localparam bit MARGIN_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lgn_class_argmax_if bus ();

    lgn_class_argmax dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int cnts [CLASSES];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bits of a group are scattered with stride 7 (coprime with 400)
    function automatic logic [Y_W-1:0] make_y();
        logic [Y_W-1:0] v;
        v = '0;
        for (int c = 0; c < CLASSES; c++) begin
            for (int i = 0; i < cnts[c]; i++) begin
                v[c*PER_CLASS + (i*7) % PER_CLASS] = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic set_all(input int val);
        for (int c = 0; c < CLASSES; c++) cnts[c] = val;
    endtask

    task automatic run_scan(input string tag, input int exp_class, input int exp_score,
                            input int exp_margin);
        int cyc;
        bus.y = make_y();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({tag, "_busy"}, 32'(bus.busy), 1);
        cyc = 1;
        while (!bus.done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_latency"}, cyc, 11);
        check_eq({tag, "_class"}, 32'(bus.class_out), exp_class);
        check_eq({tag, "_score"}, 32'(bus.score_out), exp_score);
        check_eq({tag, "_margin"}, 32'(bus.margin_out), MARGIN_ON ? exp_margin : 0);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(bus.done), 0);
        check_eq({tag, "_busy_after"}, 32'(bus.busy), 0);
        check_eq({tag, "_class_hold"}, 32'(bus.class_out), exp_class);
    endtask

    initial begin
        int ndone, first, second;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.y     = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_done", 32'(bus.done), 0);
        check_eq("rst_class", 32'(bus.class_out), 0);
        check_eq("rst_score", 32'(bus.score_out), 0);
        check_eq("rst_margin", 32'(bus.margin_out), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single winner: group 7 = 250, others 100
        set_all(100);
        cnts[7] = 250;
        run_scan("single", 7, 250, 150);

        // Asynchronous reset at idx 4 (cycle 5 of the scan)
        set_all(100);
        cnts[3] = 200;
        bus.y = make_y();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(bus.busy), 0);
        check_eq("abort_done", 32'(bus.done), 0);
        check_eq("abort_class", 32'(bus.class_out), 0);
        check_eq("abort_score", 32'(bus.score_out), 0);
        check_eq("abort_margin", 32'(bus.margin_out), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check_eq("abort_no_done", ndone, 0);
        run_scan("after_abort", 3, 200, 100);

        // Tie between groups 2 and 5
        set_all(0);
        cnts[2] = 300;
        cnts[5] = 300;
        run_scan("tie", 2, 300, 0);

        set_all(PER_CLASS);
        run_scan("all_ones", 0, 400, 0);

        set_all(0);
        run_scan("all_zeros", 0, 0, 0);

        set_all(0);
        cnts[9] = PER_CLASS;
        run_scan("last_only", 9, 400, 400);

        // Strictly increasing scores: every step displaces the best
        for (int c = 0; c < CLASSES; c++) cnts[c] = 10 * c + 10;
        run_scan("rising", 9, 100, 10);

        // Best at index 0, close second later on
        set_all(7);
        cnts[0] = 400;
        cnts[4] = 399;
        run_scan("first_best", 0, 400, 1);

        // Tie at non-zero indices after a lower first group
        set_all(0);
        cnts[0] = 50;
        cnts[3] = 51;
        cnts[8] = 51;
        run_scan("tie_mid", 3, 51, 0);

        // start together with rst: reset wins
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check_eq("rst_vs_start_busy", 32'(bus.busy), 0);

        // Handshake: starts at cycles 3 and 10 ignored, restart after done
        set_all(100);
        cnts[7] = 250;
        bus.y = make_y();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        ndone  = 0;
        first  = 0;
        second = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.done) begin
                ndone++;
                if (first == 0) first = cyc;
                else if (second == 0) second = cyc;
            end
            bus.start = (cyc == 3) || (cyc == 10) || (first != 0 && cyc == first + 1);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check_eq("hs_first_done", first, 11);
        check_eq("hs_second_done", second, 23);
        check_eq("hs_done_count", ndone, 2);
        check_eq("hs_class", 32'(bus.class_out), 7);
        check_eq("hs_score", 32'(bus.score_out), 250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
